// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, widths and defaults for the dmem_responder data-memory model.
package dmem_pkg;
    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int BE_W            = DATA_W / 8;
    localparam int CNT_W           = 4;
    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_LATENCY     = 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    // Misaligned or past the last word.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(depth));
    endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word storage with per-byte write mask and registered read data.
module dmem_array import dmem_pkg::*; #(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   mask_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i)
                for (int b = 0; b < BE_W; b++)
                    if (mask_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder with valid/ready request and response.
// Define DMEM_BYTE_EN to honour req_be on stores; otherwise every store writes the full word.
module dmem_responder import dmem_pkg::*; #(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    logic              accept, enter_resp, acc_write, acc_err;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata, arr_rdata;
    logic [BE_W-1:0]   acc_be, mask;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                accept     = 1'b1;
                enter_resp = (LATENCY == 1);
                state_d    = (LATENCY == 1) ? RESP : WAIT;
                cnt_d      = CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);
            end
            WAIT: if (cnt_q == '0) begin
                state_d    = RESP;
                enter_resp = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    // With LATENCY=1 the access happens on the accept edge, before the request is latched.
    assign acc_write = (state_q == IDLE) ? req_write : write_q;
    assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign acc_be    = (state_q == IDLE) ? req_be    : be_q;
    assign acc_err   = addr_err(acc_addr, DEPTH_WORDS);

`ifdef DMEM_BYTE_EN
    assign mask = acc_be;
`else
    assign mask = acc_be | {BE_W{1'b1}};
`endif

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk     (clk),
        .en_i    (enter_resp),
        .we_i    (acc_write & ~acc_err),
        .idx_i   (acc_addr[IDX_W+1:2]),
        .wdata_i (acc_wdata),
        .mask_i  (mask),
        .rdata_o (arr_rdata)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & addr_err(addr_q, DEPTH_WORDS);
    assign resp_rdata = (resp_valid & ~write_q & ~resp_err) ? arr_rdata : '0;
endmodule
